// File: rtl/ddr_tt_pkg.sv
// rtl/ddr_tt_pkg.sv - shared types and constants for the DDR PRBS checker
//
// Purpose: lock-state encoding, PRBS-8 feedback taps and the default
// loss-of-lock threshold shared by ddr_prbs_checker and prbs8_next.
// Optional feature macro used by the checker: DDR_PRBS_FIRST_ERR_EN.
package ddr_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Feedback taps s[7]^s[5]^s[4]^s[3]; the feedback bit enters at bit 0.
  localparam logic [7:0] PRBS_TAPS = 8'b1011_1000;

  localparam int unsigned DEFAULT_LOSS_THRESH = 4;

endpackage

// File: rtl/prbs8_next.sv
// rtl/prbs8_next.sv - one combinational step of the PRBS-8 sequence
//
// Purpose: s_o = {s_i[6:0], parity(s_i & PRBS_TAPS)}.
// Ports:
//   s_i  in  8  current sequence byte
//   s_o  out 8  next sequence byte
module prbs8_next
  import ddr_tt_pkg::*;
(
  input  logic [7:0] s_i,
  output logic [7:0] s_o
);

  assign s_o = {s_i[6:0], ^(s_i & PRBS_TAPS)};

endmodule

// File: rtl/ddr_prbs_checker.sv
// rtl/ddr_prbs_checker.sv - PRBS-8 lock/compare checker for DDR byte pairs
//
// Purpose: acquires lock on a PRBS-8 stream delivered as rise/fall byte
// pairs, then counts mismatching bytes and locked beats, drops lock after
// LOSS_THRESH consecutive mismatching beats.
// Optional first-error capture: define DDR_PRBS_FIRST_ERR_EN.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   ena        in  1      enable; low freezes all state
//   clr        in  1      synchronous clear of counters and first_err
//   in_valid   in  1      rise_byte/fall_byte carry one beat
//   rise_byte  in  8      first byte of the beat
//   fall_byte  in  8      second byte of the beat
//   locked     out 1      high while LOCKED
//   state      out 2      0 IDLE, 1 SEEK, 2 LOCKED
//   err_cnt    out CNT_W  mismatching bytes while LOCKED, saturating
//   beat_cnt   out CNT_W  beats while LOCKED, wrapping
//   first_err  out 16     {expected, received} of first mismatching byte
module ddr_prbs_checker
  import ddr_tt_pkg::*;
#(
  parameter int unsigned LOSS_THRESH = DEFAULT_LOSS_THRESH,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       rise_byte,
  input  logic [7:0]       fall_byte,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [15:0]      first_err
);

  state_e           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [3:0]       miss_q, miss_d;
  logic [3:0]       miss_inc;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W:0]   err_sum;
  logic [7:0]       next_rise, chain_in, next_b, next_c;
  logic             rise_bad, fall_bad;
  logic [1:0]       n_err;

  // The exp chain is idle in SEEK, so it is borrowed there to form
  // next(fall_byte), the expected rise byte of the beat after locking.
  assign chain_in = (state_q == ST_LOCKED) ? exp_q : fall_byte;

  prbs8_next u_next_rise (.s_i(rise_byte), .s_o(next_rise));
  prbs8_next u_next_exp  (.s_i(chain_in),  .s_o(next_b));
  prbs8_next u_next_exp2 (.s_i(next_b),    .s_o(next_c));

  assign rise_bad = (rise_byte != exp_q);
  assign fall_bad = (fall_byte != next_b);
  assign n_err    = {1'b0, rise_bad} + {1'b0, fall_bad};
  assign err_sum  = {1'b0, err_cnt_q} + {{(CNT_W-1){1'b0}}, n_err};
  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    miss_d     = miss_q;
    err_cnt_d  = err_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: state_d = ST_SEEK;
        ST_SEEK: begin
          if (in_valid && (rise_byte != 8'h00) && (fall_byte == next_rise)) begin
            state_d = ST_LOCKED;
            exp_d   = next_b;
            miss_d  = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (in_valid) begin
            exp_d      = next_c;
            beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            err_cnt_d  = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
            if (rise_bad || fall_bad) begin
              if (miss_inc == 4'(LOSS_THRESH)) begin
                state_d = ST_SEEK;
                miss_d  = 4'd0;
              end else begin
                miss_d = miss_inc;
              end
            end else begin
              miss_d = 4'd0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (clr) begin
        err_cnt_d  = '0;
        beat_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      exp_q      <= 8'h01;
      miss_q     <= 4'd0;
      err_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      miss_q     <= miss_d;
      err_cnt_q  <= err_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DDR_PRBS_FIRST_ERR_EN
  logic [15:0] first_err_q, first_err_d;

  // The expected byte is never 0x00, so a zero upper half means nothing
  // has been captured yet; no separate valid flag is needed.
  always_comb begin
    first_err_d = first_err_q;
    if (ena) begin
      if (clr) begin
        first_err_d = 16'h0000;
      end else if ((state_q == ST_LOCKED) && in_valid && (first_err_q[15:8] == 8'h00)) begin
        if (rise_bad) begin
          first_err_d = {exp_q, rise_byte};
        end else if (fall_bad) begin
          first_err_d = {next_b, fall_byte};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_q <= 16'h0000;
    end else begin
      first_err_q <= first_err_d;
    end
  end

  assign first_err = first_err_q;
`else
  assign first_err = 16'h0000;
`endif

  assign state    = state_q;
  assign locked   = (state_q == ST_LOCKED);
  assign err_cnt  = err_cnt_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_ddr_prbs_checker.sv
// tb/tb_ddr_prbs_checker.sv - self-checking bench for ddr_prbs_checker
module tb_ddr_prbs_checker;

`ifdef DDR_PRBS_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif
  localparam int LT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, clr, in_valid;
  logic [7:0]  rise_byte, fall_byte;
  logic        locked_a, locked_b;
  logic [1:0]  state_a, state_b;
  logic [15:0] err_a, beat_a, first_a, first_b;
  logic [3:0]  err_b, beat_b;

  always #5 clk = ~clk;

  ddr_prbs_checker #(.LOSS_THRESH(LT), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .rise_byte(rise_byte), .fall_byte(fall_byte), .locked(locked_a),
    .state(state_a), .err_cnt(err_a), .beat_cnt(beat_a), .first_err(first_a)
  );

  ddr_prbs_checker #(.LOSS_THRESH(LT), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .rise_byte(rise_byte), .fall_byte(fall_byte), .locked(locked_b),
    .state(state_b), .err_cnt(err_b), .beat_cnt(beat_b), .first_err(first_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 searching, 2 tracking.
  int m_mode, m_exp, m_miss, m_first;
  int m_err[2];
  int m_beat[2];
  int m_w[2] = '{16, 4};

  function automatic int nx(int s);
    int p;
    p = ((s >> 7) & 1) ^ ((s >> 5) & 1) ^ ((s >> 4) & 1) ^ ((s >> 3) & 1);
    return ((s * 2) % 256) + p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 1; m_miss = 0; m_first = 0;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_beat[k] = 0;
    end
  endtask

  task automatic model_step();
    int r, f, nerr, mx;
    bit rb, fb;
    r = int'(rise_byte); f = int'(fall_byte);
    if (!ena) return;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (in_valid && r != 0 && f == nx(r)) begin
        m_mode = 2; m_exp = nx(f); m_miss = 0;
      end
    end else if (in_valid) begin
      rb = (r != m_exp);
      fb = (f != nx(m_exp));
      nerr = int'(rb) + int'(fb);
      for (int k = 0; k < 2; k++) begin
        mx = (1 << m_w[k]) - 1;
        m_err[k]  = (m_err[k] + nerr > mx) ? mx : m_err[k] + nerr;
        m_beat[k] = (m_beat[k] + 1) % (1 << m_w[k]);
      end
      if (FE_EN && m_first == 0) begin
        if (rb)      m_first = m_exp * 256 + r;
        else if (fb) m_first = nx(m_exp) * 256 + f;
      end
      if (nerr != 0) begin
        m_miss++;
        if (m_miss == LT) begin
          m_mode = 1; m_miss = 0;
        end
      end else begin
        m_miss = 0;
      end
      m_exp = nx(nx(m_exp));
    end
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        m_err[k] = 0; m_beat[k] = 0;
      end
      m_first = 0;
    end
  endtask

  task automatic chk(string nm, int act, int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " state16"},  int'(state_a),  m_mode);
    chk({tag, " locked16"}, int'(locked_a), int'(m_mode == 2));
    chk({tag, " err16"},    int'(err_a),    m_err[0]);
    chk({tag, " beat16"},   int'(beat_a),   m_beat[0]);
    chk({tag, " first16"},  int'(first_a),  m_first);
    chk({tag, " state4"},   int'(state_b),  m_mode);
    chk({tag, " err4"},     int'(err_b),    m_err[1]);
    chk({tag, " beat4"},    int'(beat_b),   m_beat[1]);
    chk({tag, " first4"},   int'(first_b),  m_first);
  endtask

  task automatic step(bit e, bit c, bit v, logic [7:0] r, logic [7:0] f);
    ena = e; clr = c; in_valid = v; rise_byte = r; fall_byte = f;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit         e;
    bit         c;
    bit         v;
    logic [7:0] r;
    logic [7:0] f;
    int         st;
    int         err;
    int         beat;
    int         fe;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 2, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h04, 8'hFF, 2, 1, 1, 16'h08FF};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h23, 2, 1, 2, 16'h08FF};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h47, 8'h8E, 2, 1, 3, 16'h08FF};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2, 1, 3, 16'h08FF};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2, 1, 3, 16'h08FF};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h1C, 8'h38, 2, 1, 4, 16'h08FF};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 2, 3, 5, 16'h08FF};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 2, 5, 6, 16'h08FF};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 2, 7, 7, 16'h08FF};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1, 9, 8, 16'h08FF};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1, 0, 0, 0};

    rst_n = 1'b0; ena = 1'b0; clr = 1'b0; in_valid = 1'b0;
    rise_byte = 8'h00; fall_byte = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset state",  int'(state_a),  0);
    chk("reset locked", int'(locked_a), 0);
    chk("reset err",    int'(err_a),    0);
    chk("reset beat",   int'(beat_a),   0);
    chk("reset first",  int'(first_a),  0);
    rst_n = 1'b1;

    // Directed table: lock, single error, gaps, loss of lock, clear.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].r, tbl[i].f);
      chk($sformatf("tbl%0d state", i),  int'(state_a),  tbl[i].st);
      chk($sformatf("tbl%0d locked", i), int'(locked_a), int'(tbl[i].st == 2));
      chk($sformatf("tbl%0d err", i),    int'(err_a),    tbl[i].err);
      chk($sformatf("tbl%0d beat", i),   int'(beat_a),   tbl[i].beat);
      chk($sformatf("tbl%0d first", i),  int'(first_a),  FE_EN ? tbl[i].fe : 0);
      check_model($sformatf("tbl%0d", i));
    end

    // Saturation of the 4-bit instance: three bad beats then one good beat
    // per round, so lock is held while errors pile up.
    step(1, 0, 1, 8'h01, 8'h02);
    check_model("sat lock");
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int j = 0; j < 3; j++) begin
        step(1, 0, 1, 8'h00, 8'h00);
        check_model("sat bad");
      end
      step(1, 0, 1, 8'(m_exp), 8'(nx(m_exp)));
      check_model("sat good");
    end
    chk("sat err4",  int'(err_b), 15);
    chk("sat err16", int'(err_a), 18);
    step(1, 1, 1, 8'h00, 8'h00);
    chk("clr err16", int'(err_a), 0);
    chk("clr err4",  int'(err_b), 0);
    chk("clr beat",  int'(beat_a), 0);
    check_model("clr");

    // Asynchronous reset in the middle of a locked stream.
    #2 rst_n = 1'b0;
    #1;
    chk("arst state",  int'(state_a),  0);
    chk("arst locked", int'(locked_a), 0);
    chk("arst err",    int'(err_a),    0);
    chk("arst beat",   int'(beat_a),   0);
    chk("arst first",  int'(first_a),  0);
    model_reset();
    rst_n = 1'b1;
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 1, 8'h01, 8'h02);
    chk("relock", int'(locked_a), 1);
    check_model("relock");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit e, c, v;
      logic [7:0] r, f;
      e = ($urandom_range(0, 99) < 90);
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 3);
      r = 8'($urandom);
      f = 8'($urandom);
      if (m_mode == 2 && $urandom_range(0, 99) < 75) begin
        r = 8'(m_exp);
        f = 8'(nx(m_exp));
        if ($urandom_range(0, 99) < 10) f = f ^ 8'h10;
      end else if (m_mode == 1 && $urandom_range(0, 99) < 40) begin
        r = 8'($urandom_range(1, 255));
        f = 8'(nx(int'(r)));
      end
      step(e, c, v, r, f);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
